// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 keyboard frame receiver with piano-key state tracking
//
// Purpose:
//    Receives PS/2 frames (start, 8 data LSB first, odd parity, stop) from a raw
//    keyboard bus, reports each good byte, flags bad or stalled frames, and keeps
//    a held/released flag for seven piano keys (A S D F G H J) from make/break codes.
//
// Ports:
//    clk         in   system clock, all state changes on its rising edge
//    rst_n       in   synchronous active-low reset
//    ps2_clk     in   raw PS/2 clock, asynchronous to clk
//    ps2_data    in   raw PS/2 data, asynchronous to clk
//    key_a..key_j out  held flag per piano key
//    scan_code   out  last correctly received byte
//    scan_valid  out  one-cycle pulse when scan_code is updated
//    frame_err   out  one-cycle pulse on parity, stop-bit or timeout failure

module ps2_key_tracker #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_a,
   output logic       key_s,
   output logic       key_d,
   output logic       key_f,
   output logic       key_g,
   output logic       key_h,
   output logic       key_j,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_err
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   // Synchronizers and edge history; all reset high so release from reset
   // looks like an idle bus rather than a falling edge.
   logic          r_clk_meta;
   logic          r_clk_sync;
   logic          r_clk_prev;
   logic          r_dat_meta;
   logic          r_dat_sync;

   logic [1:0]    r_state;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_par;
   logic [TW-1:0] r_tmo;

   logic          r_brk;
   logic          r_ext;
   logic [6:0]    r_keys;      // bit 0 = a ... bit 6 = j
   logic [7:0]    r_scan_code;
   logic          r_scan_valid;
   logic          r_frame_err;

   logic          w_fall;
   logic          w_good;
   logic [6:0]    w_keys_nxt;
   logic          w_brk_nxt;
   logic          w_ext_nxt;

   assign w_fall = r_clk_prev & ~r_clk_sync;

   // Evaluated on the stop-bit edge: r_shift holds the byte, r_par the parity
   // bit, and r_dat_sync is the stop bit itself.
   assign w_good = r_dat_sync & (^{r_shift, r_par});

   // Decoder outcome for a good byte sitting in r_shift.
   always_comb begin
      w_keys_nxt = r_keys;
      w_brk_nxt  = 1'b0;
      w_ext_nxt  = 1'b0;
      if (r_shift == 8'hF0) begin
         w_brk_nxt = 1'b1;
         w_ext_nxt = r_ext;
      end else if (r_shift == 8'hE0) begin
         w_ext_nxt = 1'b1;
         w_brk_nxt = r_brk;
      end else if (!r_ext) begin
         // Extended codes fall through with keys untouched.
         case (r_shift)
            8'h00, 8'hFF: w_keys_nxt    = 7'd0;   // keyboard overrun
            8'h1C:        w_keys_nxt[0] = ~r_brk;
            8'h1B:        w_keys_nxt[1] = ~r_brk;
            8'h23:        w_keys_nxt[2] = ~r_brk;
            8'h2B:        w_keys_nxt[3] = ~r_brk;
            8'h34:        w_keys_nxt[4] = ~r_brk;
            8'h33:        w_keys_nxt[5] = ~r_brk;
            8'h3B:        w_keys_nxt[6] = ~r_brk;
            default:      ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_clk_meta   <= 1'b1;
         r_clk_sync   <= 1'b1;
         r_clk_prev   <= 1'b1;
         r_dat_meta   <= 1'b1;
         r_dat_sync   <= 1'b1;
         r_state      <= ST_IDLE;
         r_bit_cnt    <= 3'd0;
         r_shift      <= 8'd0;
         r_par        <= 1'b0;
         r_tmo        <= '0;
         r_brk        <= 1'b0;
         r_ext        <= 1'b0;
         r_keys       <= 7'd0;
         r_scan_code  <= 8'd0;
         r_scan_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_clk_meta   <= ps2_clk;
         r_clk_sync   <= r_clk_meta;
         r_clk_prev   <= r_clk_sync;
         r_dat_meta   <= ps2_data;
         r_dat_sync   <= r_dat_meta;
         r_scan_valid <= 1'b0;
         r_frame_err  <= 1'b0;

         if (w_fall) begin
            r_tmo <= '0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_fall && !r_dat_sync) begin
                  r_state   <= ST_DATA;
                  r_bit_cnt <= 3'd0;
               end
            end
            ST_DATA: begin
               if (w_fall) begin
                  r_shift   <= {r_dat_sync, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= ST_PARITY;
                  end
               end
            end
            ST_PARITY: begin
               if (w_fall) begin
                  r_par   <= r_dat_sync;
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_fall) begin
                  r_state <= ST_IDLE;
                  if (w_good) begin
                     r_scan_code  <= r_shift;
                     r_scan_valid <= 1'b1;
                     r_keys       <= w_keys_nxt;
                     r_brk        <= w_brk_nxt;
                     r_ext        <= w_ext_nxt;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_brk       <= 1'b0;
                     r_ext       <= 1'b0;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // Stall watchdog: only runs mid-frame and never in an edge cycle, so
         // it cannot collide with the stop-bit evaluation above.
         if (r_state != ST_IDLE && !w_fall) begin
            if (r_tmo == TMO_LAST) begin
               r_state     <= ST_IDLE;
               r_frame_err <= 1'b1;
               r_brk       <= 1'b0;
               r_ext       <= 1'b0;
               r_tmo       <= '0;
            end else begin
               r_tmo <= r_tmo + TW'(1);
            end
         end
      end
   end

   assign key_a      = r_keys[0];
   assign key_s      = r_keys[1];
   assign key_d      = r_keys[2];
   assign key_f      = r_keys[3];
   assign key_g      = r_keys[4];
   assign key_h      = r_keys[5];
   assign key_j      = r_keys[6];
   assign scan_code  = r_scan_code;
   assign scan_valid = r_scan_valid;
   assign frame_err  = r_frame_err;

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, clk cycles without a PS/2 falling edge before an in-progress frame is aborted.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-005 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-006 key_a, key_s, key_d, key_f, key_g, key_h, key_j  output  1 each  held flag per piano key; high while the key is down.
REQ-007 scan_code  output  8  last correctly received byte.
REQ-008 scan_valid  output  1  one-cycle pulse when scan_code is updated.
REQ-009 frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout failure.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is synced-previous 1, synced-current 0.
REQ-011 Data SHALL be sampled from synced ps2_data only in the cycle a falling edge is detected.
REQ-012 Frame SHALL be 11 bits: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-013 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: edge with data 0 -> DATA, bit counter 0; edge with data 1 ignored, stay IDLE.
REQ-015 DATA: each edge shifts one bit in; after the 8th edge -> PARITY.
REQ-016 PARITY: next edge captures parity bit -> STOP.
REQ-017 STOP: next edge captures stop bit -> IDLE, frame evaluated the same edge.
REQ-018 Frame good when stop = 1 and the XOR of the 8 data bits and the parity bit is 1.
REQ-019 Good frame: scan_code loaded and scan_valid pulsed in the cycle after the stop-bit edge is detected (1-cycle latency).
REQ-020 Bad frame: frame_err pulsed with the same timing; scan_code, scan_valid and key flags unchanged.
REQ-021 Timeout counter SHALL reset on every edge and count while not IDLE; reaching TIMEOUT_CYCLES -> IDLE plus one frame_err pulse.
REQ-022 Decoder flags break_pend and ext_pend SHALL be internal registers, both 0 after reset.
REQ-023 Good byte F0 -> set break_pend; E0 -> set ext_pend; neither changes key flags.
REQ-024 Any other good byte with ext_pend = 1 -> keys unchanged; both pends cleared.
REQ-025 Otherwise codes 1C/1B/23/2B/34/33/3B map to key_a/s/d/f/g/h/j respectively; mapped flag <= NOT break_pend; both pends cleared.
REQ-026 Good byte 00 or FF (keyboard overrun): all seven key flags cleared; both pends cleared.
REQ-027 Any other unmapped good byte (incl. AA, FA, typematic repeats of unmapped keys) -> keys unchanged; pends cleared.
REQ-028 Key flags SHALL update on the same clock edge that asserts scan_valid.
REQ-029 Every frame_err (parity, stop, timeout) SHALL clear both pends; key flags retained.
REQ-030 Key flags are independent; any combination may be high at once; repeated make of a held key leaves it high.
REQ-031 scan_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-032 While rst_n = 0 at a clk edge: FSM IDLE, counters 0, shift register 0, pends 0, all outputs 0.
REQ-033 Synchronizer flops SHALL reset to 1 (idle bus) so no false edge follows reset release.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame with no scan_valid or frame_err pulse.

Verification
REQ-035 Frame 0x1C, parity 0 -> scan_code 1C, one scan_valid pulse, key_a 1; then frames F0, 1C -> key_a 0, two scan_valid pulses, no frame_err.
REQ-036 Make 1C, 23, 3B -> key_a, key_d, key_j all 1, others 0; byte FF -> all keys 0.
REQ-037 Frame 0x1B with wrong parity -> frame_err pulse, key_s stays 0, scan_code unchanged.
REQ-038 Frames E0, 1C -> key_a unchanged; then F0 sent, ps2_clk held high for TIMEOUT_CYCLES mid-next-frame -> one frame_err; next 1C -> key_a 1 (break_pend cleared).
REQ-039 rst_n low after 5 data bits of a frame, then released -> no pulses, outputs 0; next full frame 0x34 -> key_g 1.
